// File: rtl/ascon_hash_serial_host.sv
// ascon_hash_serial_host
// Host-side driver for the bit-serial Ascon hash core.
// A parallel message is latched on request and shifted out MSB first, one bit
// per cycle, together with ten fresh random bits per cycle. The core is then
// started, its latency is measured, and the serial hash is collected LSB first
// into a parallel result.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   reqxSI / ackxSO   request (sampled in IDLE) / one-cycle accept pulse
//   messagexDI        parallel message (Y bits)
//   randxDI           10 bits of fresh randomness, consumed each load cycle
//   messagexSO        to core: {rand[1:0], message bit}
//   r_64xSO           to core: rand[8:2]
//   r_faultxSO        to core: rand[9]
//   startxSO          to core: start, held START_LEN cycles
//   readyxSI          from core: hash ready
//   hash_textxSI      from core: serial hash bit
//   hashxDO           parallel hash result (L bits)
//   cyclesxDO         cycles from first start-high cycle to ready-high cycle
//   validxDO          result valid, held until takexSI
//   takexSI           result consumed
//
// START_LEN and GAP must both be at least 1.
module ascon_hash_serial_host #(
    parameter int Y         = 80,
    parameter int L         = 256,
    parameter int MAX       = 256,
    parameter int START_LEN = 3,
    parameter int GAP       = 2,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reqxSI,
    output logic          ackxSO,
    input  logic [Y-1:0]  messagexDI,
    input  logic [9:0]    randxDI,
    output logic [2:0]    messagexSO,
    output logic [6:0]    r_64xSO,
    output logic          r_faultxSO,
    output logic          startxSO,
    input  logic          readyxSI,
    input  logic          hash_textxSI,
    output logic [L-1:0]  hashxDO,
    output logic [CW-1:0] cyclesxDO,
    output logic          validxDO,
    input  logic          takexSI
);

    // One shared phase index covers the longest of the counted phases.
    localparam int CNT_MAX = (MAX > L) ? MAX : L;
    localparam int IW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [IW-1:0] LOAD_LAST  = IW'(MAX - 1);
    localparam logic [IW-1:0] START_LAST = IW'(START_LEN - 1);
    localparam logic [IW-1:0] GAP_LAST   = IW'(GAP - 1);
    localparam logic [IW-1:0] READ_LAST  = IW'(L - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4,
        S_READ  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t        state_r;
    logic [IW-1:0] idx_r;
    logic [Y-1:0]  msg_r;
    logic [CW-1:0] cnt_r;

    // Latency counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    // Host FSM: serial load, start pulse, latency count, gap, serial read, handoff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            idx_r      <= {IW{1'b0}};
            msg_r      <= {Y{1'b0}};
            cnt_r      <= {CW{1'b0}};
            ackxSO     <= 1'b0;
            messagexSO <= 3'b000;
            r_64xSO    <= 7'b0000000;
            r_faultxSO <= 1'b0;
            startxSO   <= 1'b0;
            hashxDO    <= {L{1'b0}};
            cyclesxDO  <= {CW{1'b0}};
            validxDO   <= 1'b0;
        end else begin
            ackxSO <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (reqxSI) begin
                        msg_r   <= messagexDI;
                        ackxSO  <= 1'b1;
                        idx_r   <= {IW{1'b0}};
                        state_r <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    {r_faultxSO, r_64xSO, messagexSO[2:1]} <= randxDI;
                    // Shifting left sends MSB first and feeds zeros once the
                    // message is exhausted, so no bounds check is needed.
                    messagexSO[0] <= msg_r[Y-1];
                    msg_r         <= {msg_r[Y-2:0], 1'b0};
                    if (idx_r == LOAD_LAST) begin
                        idx_r   <= {IW{1'b0}};
                        state_r <= S_START;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                S_START: begin
                    messagexSO <= 3'b000;
                    r_64xSO    <= 7'b0000000;
                    r_faultxSO <= 1'b0;
                    startxSO   <= 1'b1;
                    // The edge that raises start zeroes the counter, so the
                    // counter equals the cycle number counted from start-high.
                    cnt_r <= (idx_r == {IW{1'b0}}) ? {CW{1'b0}} : sat_inc(cnt_r);
                    if (idx_r == START_LAST) begin
                        idx_r   <= {IW{1'b0}};
                        state_r <= S_WAIT;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                S_WAIT: begin
                    startxSO <= 1'b0;
                    cnt_r    <= sat_inc(cnt_r);
                    if (readyxSI) begin
                        cyclesxDO <= cnt_r;
                        idx_r     <= {IW{1'b0}};
                        state_r   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (idx_r == GAP_LAST) begin
                        idx_r   <= {IW{1'b0}};
                        state_r <= S_READ;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                S_READ: begin
                    hashxDO[idx_r] <= hash_textxSI;
                    if (idx_r == READ_LAST) begin
                        idx_r    <= {IW{1'b0}};
                        validxDO <= 1'b1;
                        state_r  <= S_DONE;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                S_DONE: begin
                    if (takexSI) begin
                        validxDO <= 1'b0;
                        state_r  <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
